turn_arbiter: RTL and testbench

- Owns the 18-bit game board register and sequences play between the human input path (player1, code 11) and the AI move generator (player2, code 10).
- Grants the single board write port to whichever side holds the turn and rejects illegal moves.
- After every write, evaluates the 8 win lines and the move count, then publishes game status.
- Drives the cellState/turn indication that the AI consumes; the AI's writeToBoard/addr pair feeds the aiValid/aiAddr inputs.

---
 rtl/turn_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_turn_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/turn_arbiter.sv
// Tic-tac-toe turn arbiter: owns the board, grants the write port, scores games.
// Optional per-turn forfeit timer is built only when TURN_TIMEOUT_EN is defined.
module turn_arbiter #(
   parameter logic [1:0] FIRST_PLAYER   = 2'b11,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input  logic        ph1,
   input  logic        reset,
   input  logic        start,
   input  logic        p1Valid,
   input  logic [3:0]  p1Addr,
   input  logic        aiValid,
   input  logic [3:0]  aiAddr,
   output logic        p1Ready,
   output logic        aiReady,
   output logic        illegalMove,
   output logic [1:0]  cellState,
   output logic [17:0] gBoard,
   output logic [1:0]  status,
   output logic [3:0]  moveCount,
   output logic        timeout
);

   localparam logic [1:0] P1   = 2'b11;
   localparam logic [1:0] P2   = 2'b10;
   localparam logic [1:0] TIE  = 2'b01;
   localparam logic [3:0] FULL = 4'd9;

   typedef enum logic [1:0] {
      IDLE,
      TURN,
      CHECK,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  mover_q, mover_d;
   logic [17:0] board_q, board_d;
   logic [1:0]  status_q, status_d;
   logic [3:0]  count_q, count_d;

   logic        req_valid;
   logic [3:0]  req_addr;
   logic [1:0]  req_cell;
   logic        in_turn;
   logic        legal;
   logic        accept;
   logic        reject;
   logic        win;
   logic        tmo_hit;

   function automatic logic [1:0] cell_at(
      input logic [17:0] b,
      input logic [3:0]  a
   );
      logic [1:0] c;
      c = 2'b00;
      for (int i = 0; i < 9; i++) begin
         if (a == 4'(i)) c = b[2*i +: 2];
      end
      return c;
   endfunction

   function automatic logic [17:0] cell_wr(
      input logic [17:0] b,
      input logic [3:0]  a,
      input logic [1:0]  v
   );
      logic [17:0] r;
      r = b;
      for (int i = 0; i < 9; i++) begin
         if (a == 4'(i)) r[2*i +: 2] = v;
      end
      return r;
   endfunction

   function automatic logic line3(
      input logic [17:0] b,
      input logic [1:0]  code,
      input int          x,
      input int          y,
      input int          z
   );
      return (b[2*x +: 2] == code) &&
             (b[2*y +: 2] == code) &&
             (b[2*z +: 2] == code);
   endfunction

   function automatic logic has_win(
      input logic [17:0] b,
      input logic [1:0]  code
   );
      return line3(b, code, 0, 1, 2) ||
             line3(b, code, 3, 4, 5) ||
             line3(b, code, 6, 7, 8) ||
             line3(b, code, 0, 3, 6) ||
             line3(b, code, 1, 4, 7) ||
             line3(b, code, 2, 5, 8) ||
             line3(b, code, 0, 4, 8) ||
             line3(b, code, 2, 4, 6);
   endfunction

   // Only the player holding the turn is ever looked at.
   always_comb begin
      req_valid = (mover_q == P1) ? p1Valid : aiValid;
      req_addr  = (mover_q == P1) ? p1Addr  : aiAddr;
      req_cell  = cell_at(board_q, req_addr);
      in_turn   = (state_q == TURN) && !start;
      legal     = (req_addr <= 4'd8) && (req_cell == 2'b00);
      accept    = in_turn && req_valid && legal;
      reject    = in_turn && req_valid && !legal;
      win       = has_win(board_q, mover_q);
   end

`ifdef TURN_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tmo_q, tmo_d;

   always_comb begin
      tmo_hit = in_turn && !accept && (tmo_q == TMO_LAST);
      tmo_d   = '0;
      if (in_turn && !accept && !tmo_hit) tmo_d = tmo_q + 1'b1;
   end

   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) tmo_q <= '0;
      else        tmo_q <= tmo_d;
   end
`else
   assign tmo_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

   always_comb begin
      state_d  = state_q;
      mover_d  = mover_q;
      board_d  = board_q;
      status_d = status_q;
      count_d  = count_q;
      unique case (state_q)
         IDLE: ;
         TURN: begin
            if (accept) begin
               board_d = cell_wr(board_q, req_addr, mover_q);
               count_d = (count_q == FULL) ? FULL : count_q + 4'd1;
               state_d = CHECK;
            end else if (tmo_hit) begin
               mover_d = (mover_q == P1) ? P2 : P1;
            end
         end
         CHECK: begin
            // A line on the ninth move is a win, not a tie.
            if (win) begin
               status_d = mover_q;
               state_d  = DONE;
            end else if (count_q == FULL) begin
               status_d = TIE;
               state_d  = DONE;
            end else begin
               mover_d = (mover_q == P1) ? P2 : P1;
               state_d = TURN;
            end
         end
         DONE: ;
         default: state_d = IDLE;
      endcase
      if (start) begin
         board_d  = '0;
         status_d = 2'b00;
         count_d  = 4'd0;
         mover_d  = FIRST_PLAYER;
         state_d  = TURN;
      end
   end

   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         mover_q  <= FIRST_PLAYER;
         board_q  <= '0;
         status_q <= 2'b00;
         count_q  <= 4'd0;
      end else begin
         state_q  <= state_d;
         mover_q  <= mover_d;
         board_q  <= board_d;
         status_q <= status_d;
         count_q  <= count_d;
      end
   end

   assign p1Ready     = accept && (mover_q == P1);
   assign aiReady     = accept && (mover_q == P2);
   assign illegalMove = reject;
   assign timeout     = tmo_hit;
   assign cellState   = (state_q == TURN || state_q == CHECK) ? mover_q
                                                             : 2'b00;
   assign gBoard      = board_q;
   assign status      = status_q;
   assign moveCount   = count_q;

endmodule

// File: tb/tb_turn_arbiter.sv
// Scoreboard bench for turn_arbiter: stimulus queues expected handshake
// pulses, a negedge monitor pops and compares them.
module tb_turn_arbiter;

   logic        ph1 = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        p1Valid = 1'b0;
   logic [3:0]  p1Addr = 4'd0;
   logic        aiValid = 1'b0;
   logic [3:0]  aiAddr = 4'd0;
   logic        p1Ready;
   logic        aiReady;
   logic        illegalMove;
   logic [1:0]  cellState;
   logic [17:0] gBoard;
   logic [1:0]  status;
   logic [3:0]  moveCount;
   logic        timeout;

   localparam logic [1:0] H  = 2'b11;
   localparam logic [1:0] A  = 2'b10;
   localparam logic [2:0] KP = 3'b100;
   localparam logic [2:0] KA = 3'b010;
   localparam logic [2:0] KI = 3'b001;

   turn_arbiter #(
      .FIRST_PLAYER  (2'b11),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .ph1        (ph1),
      .reset      (reset),
      .start      (start),
      .p1Valid    (p1Valid),
      .p1Addr     (p1Addr),
      .aiValid    (aiValid),
      .aiAddr     (aiAddr),
      .p1Ready    (p1Ready),
      .aiReady    (aiReady),
      .illegalMove(illegalMove),
      .cellState  (cellState),
      .gBoard     (gBoard),
      .status     (status),
      .moveCount  (moveCount),
      .timeout    (timeout)
   );

   always #5 ph1 = ~ph1;

   int nchk = 0;
   int npass = 0;
   logic [2:0] expq[$];

   task automatic chk(input string name, input logic [17:0] act,
                      input logic [17:0] exp);
      nchk++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   always @(negedge ph1) begin
      logic [2:0] got;
      logic [2:0] want;
      got = {p1Ready, aiReady, illegalMove};
      if (got != 3'b000) begin
         nchk++;
         if (expq.size() == 0) begin
            $display("FAIL unexpected-pulse: got %b want none", got);
         end else begin
            want = expq.pop_front();
            if (got == want) npass++;
            else $display("FAIL pulse: got %b want %b", got, want);
         end
      end
   end

   task automatic do_start();
      start = 1'b1;
      @(posedge ph1); #1;
      start = 1'b0;
   endtask

   // Legal moves return after the CHECK cycle; illegal ones stay in TURN.
   task automatic play(input logic [1:0] who, input logic [3:0] a,
                       input logic [2:0] want);
      bit seen = 0;
      expq.push_back(want);
      if (who == H) begin p1Valid = 1'b1; p1Addr = a; end
      else begin aiValid = 1'b1; aiAddr = a; end
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge ph1);
         if ({p1Ready, aiReady, illegalMove} != 3'b000) seen = 1;
      end
      if (!seen) begin
         nchk++;
         $display("FAIL wait-pulse: got none want %b", want);
      end
      @(posedge ph1); #1;
      p1Valid = 1'b0;
      aiValid = 1'b0;
      if (want != KI) begin
         @(posedge ph1); #1;
      end
   endtask

   task automatic hold(input logic [1:0] who, input logic [3:0] a,
                       input int n);
      if (who == H) begin p1Valid = 1'b1; p1Addr = a; end
      else begin aiValid = 1'b1; aiAddr = a; end
      repeat (n) @(posedge ph1);
      #1;
      p1Valid = 1'b0;
      aiValid = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge ph1);
      #1;
      chk("rst-board", gBoard, 18'd0);
      chk("rst-status", 18'(status), 18'd0);
      chk("rst-count", 18'(moveCount), 18'd0);
      chk("rst-cell", 18'(cellState), 18'd0);
      chk("rst-pulses", 18'({p1Ready, aiReady, illegalMove, timeout}), 18'd0);
      reset = 1'b1;
      @(posedge ph1); #1;

      do_start();
      chk("start-cell", 18'(cellState), 18'(H));
      chk("start-board", gBoard, 18'd0);
      chk("start-status", 18'(status), 18'd0);
      chk("start-count", 18'(moveCount), 18'd0);

      play(H, 4'd0, KP);
      play(A, 4'd3, KA);
      play(H, 4'd1, KP);
      play(A, 4'd4, KA);
      play(H, 4'd2, KP);
      chk("row-status", 18'(status), 18'(H));
      chk("row-bits", 18'(gBoard[5:0]), 18'b111111);
      chk("row-board", gBoard, 18'b00_00_00_00_10_10_11_11_11);
      chk("row-count", 18'(moveCount), 18'd5);
      chk("row-cell", 18'(cellState), 18'd0);
      hold(A, 4'd5, 3);
      chk("done-hold", gBoard, 18'b00_00_00_00_10_10_11_11_11);

      do_start();
      play(H, 4'd0, KP);
      hold(H, 4'd1, 3);
      chk("wrong-turn-board", gBoard, 18'h00003);
      chk("wrong-turn-cell", 18'(cellState), 18'(A));
      play(A, 4'd0, KI);
      play(A, 4'd9, KI);
      chk("illegal-board", gBoard, 18'h00003);
      play(A, 4'd5, KA);
      chk("retry-cell", 18'(cellState), 18'(H));
      chk("retry-board", gBoard, 18'h00803);

      do_start();
      play(H, 4'd0, KP);
      play(A, 4'd1, KA);
      play(H, 4'd2, KP);
      play(A, 4'd4, KA);
      play(H, 4'd3, KP);
      play(A, 4'd5, KA);
      play(H, 4'd7, KP);
      play(A, 4'd6, KA);
      play(H, 4'd8, KP);
      chk("tie-status", 18'(status), 18'b01);
      chk("tie-count", 18'(moveCount), 18'd9);
      chk("tie-board", gBoard, 18'b11_11_10_10_10_11_11_10_11);
      chk("tie-cell", 18'(cellState), 18'd0);

      do_start();
      play(H, 4'd0, KP);
      play(A, 4'd1, KA);
      play(H, 4'd2, KP);
      play(A, 4'd4, KA);
      play(H, 4'd3, KP);
      play(A, 4'd5, KA);
      play(H, 4'd7, KP);
      play(A, 4'd8, KA);
      play(H, 4'd6, KP);
      chk("win9-status", 18'(status), 18'(H));
      chk("win9-count", 18'(moveCount), 18'd9);

      do_start();
      play(H, 4'd0, KP);
      start = 1'b1;
      aiValid = 1'b1;
      aiAddr = 4'd4;
      @(posedge ph1); #1;
      start = 1'b0;
      aiValid = 1'b0;
      chk("restart-board", gBoard, 18'd0);
      chk("restart-cell", 18'(cellState), 18'(H));
      chk("restart-count", 18'(moveCount), 18'd0);
      chk("restart-status", 18'(status), 18'd0);

`ifdef TURN_TIMEOUT_EN
      begin
         int at;
         at = -1;
         do_start();
         for (int i = 0; i < 8; i++) begin
            @(negedge ph1);
            if (timeout && at < 0) at = i;
         end
         chk("tmo-cycle", 18'(at), 18'd7);
         @(posedge ph1); #1;
         chk("tmo-cell", 18'(cellState), 18'(A));
         chk("tmo-board", gBoard, 18'd0);
         repeat (7) @(posedge ph1);
         #1;
         expq.push_back(KA);
         aiValid = 1'b1;
         aiAddr = 4'd0;
         @(negedge ph1);
         chk("tmo-accept-wins", 18'(timeout), 18'd0);
         @(posedge ph1); #1;
         aiValid = 1'b0;
         @(posedge ph1); #1;
         chk("tmo-accept-board", gBoard, 18'h00002);
      end
`else
      chk("tmo-tied", 18'(timeout), 18'd0);
`endif

      repeat (2) @(posedge ph1);
      chk("queue-empty", 18'(expq.size()), 18'd0);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
